// File: rtl/dso_rd_ctrl_pkg.sv
// Shared types and default sizes for the DSO capture-buffer read side.
package dso_rd_ctrl_pkg;

  localparam int DSO_ADDR_W    = 9;
  localparam int DSO_DATA_W    = 8;
  localparam int DSO_REARM_CYC = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_HOLD,
    ST_REARM
  } rd_state_e;

endpackage

// File: rtl/dso_rd_ctrl_if.sv
// Sample stream from the capture buffer to the display/NIOS side (valid/ready).
interface dso_rd_ctrl_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] smp_data;
  logic              smp_valid;
  logic              smp_last;
  logic              smp_ready;

  modport master (
    output smp_data,
    output smp_valid,
    output smp_last,
    input  smp_ready
  );

  modport slave (
    input  smp_data,
    input  smp_valid,
    input  smp_last,
    output smp_ready
  );

endinterface

// File: rtl/dso_rd_ctrl_sync.sv
// Generic 1-bit two-flop synchronizer with asynchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops give the first stage a full cycle to resolve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/dso_rd_ctrl.sv
// Reads a full capture from RAM with a programmable stride, streams it out over
// valid/ready and then pulses cap_en low to re-arm the writer.
module dso_rd_ctrl
  import dso_rd_ctrl_pkg::*;
#(
  parameter int ADDR_W    = DSO_ADDR_W,
  parameter int DATA_W    = DSO_DATA_W,
  parameter int REARM_CYC = DSO_REARM_CYC
) (
  input  logic              clk_rd,
  input  logic              rst_n,
  input  logic              cap_irq,
  input  logic              rd_arm,
  input  logic              rd_abort,
  input  logic [ADDR_W-1:0] rd_step,
  output logic [ADDR_W-1:0] rdaddr,
  input  logic [DATA_W-1:0] rddata,
  dso_rd_ctrl_if.master     smp,
  output logic              cap_en,
  output logic              rd_busy,
  output logic              rd_done
);

  localparam int CNT_W = (REARM_CYC > 1) ? $clog2(REARM_CYC) : 1;

  rd_state_e         state_q, state_d;
  logic              irq_s;
  logic              irq_prev_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] step_q, step_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              cap_en_q, cap_en_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  rearm_cnt_q, rearm_cnt_d;
  logic [ADDR_W:0]   addr_sum;
  logic              start;
  logic              accept;
  logic              abort_req;

  sync_2ff u_irq_sync (
    .clk   (clk_rd),
    .rst_n (rst_n),
    .d_i   (cap_irq),
    .q_o   (irq_s)
  );

  // One extra bit so a step past the top of RAM shows up as a carry, never a wrap.
  assign addr_sum  = {1'b0, addr_q} + {1'b0, step_q};
  assign start     = (state_q == ST_IDLE) && irq_s && !irq_prev_q && rd_arm;
  assign accept    = (state_q == ST_HOLD) && valid_q && smp.smp_ready;
  assign abort_req = rd_abort && (state_q inside {ST_FETCH, ST_LOAD, ST_HOLD});

  // State and datapath registers.
  always_ff @(posedge clk_rd or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      irq_prev_q  <= 1'b0;
      addr_q      <= '0;
      step_q      <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      cap_en_q    <= 1'b1;
      done_q      <= 1'b0;
      rearm_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      irq_prev_q  <= irq_s;
      addr_q      <= addr_d;
      step_q      <= step_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      cap_en_q    <= cap_en_d;
      done_q      <= done_d;
      rearm_cnt_q <= rearm_cnt_d;
    end
  end

  // Next-state logic; an abort overrides whatever the handshake would do.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_HOLD;
      ST_HOLD:  if (accept) state_d = last_q ? ST_REARM : ST_FETCH;
      // Leave only once the pulse is over and the irq level has dropped.
      ST_REARM: if (cap_en_q && !irq_s) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort_req) state_d = ST_REARM;
  end

  // Datapath / output next values per state.
  always_comb begin
    addr_d      = addr_q;
    step_d      = step_q;
    data_d      = data_q;
    valid_d     = valid_q;
    last_d      = last_q;
    cap_en_d    = cap_en_q;
    done_d      = 1'b0;
    rearm_cnt_d = rearm_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        addr_d = '0;
        if (start) step_d = (rd_step == '0) ? ADDR_W'(1) : rd_step;
      end
      ST_FETCH: begin
      end
      ST_LOAD: begin
        data_d  = rddata;
        valid_d = 1'b1;
        last_d  = addr_sum[ADDR_W];
      end
      ST_HOLD: begin
        if (accept) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (last_q) begin
            done_d      = 1'b1;
            cap_en_d    = 1'b0;
            rearm_cnt_d = '0;
          end else begin
            addr_d = addr_sum[ADDR_W-1:0];
          end
        end
      end
      ST_REARM: begin
        addr_d = '0;
        if (!cap_en_q) begin
          if (rearm_cnt_q == CNT_W'(REARM_CYC - 1)) cap_en_d = 1'b1;
          else rearm_cnt_d = rearm_cnt_q + CNT_W'(1);
        end
      end
      default: begin
      end
    endcase
    if (abort_req) begin
      valid_d     = 1'b0;
      last_d      = 1'b0;
      done_d      = 1'b0;
      cap_en_d    = 1'b0;
      rearm_cnt_d = '0;
    end
  end

  assign rdaddr        = addr_q;
  assign smp.smp_data  = data_q;
  assign smp.smp_valid = valid_q;
  assign smp.smp_last  = last_q;
  assign cap_en        = cap_en_q;
  assign rd_done       = done_q;
  assign rd_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dso_rd_ctrl.sv
// Self-checking bench for dso_rd_ctrl: table of frames plus hand-written corner cases.
module tb_dso_rd_ctrl;

  localparam int ADDR_W    = 9;
  localparam int DATA_W    = 8;
  localparam int REARM_CYC = 4;
  localparam int DEPTH     = 512;

  typedef struct {
    int step;
    int stall;
    int rnd;
    int exp_n;
    int exp_last;
  } frame_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         addr;
  } exp_t;

  logic              clk_rd   = 1'b0;
  logic              rst_n    = 1'b0;
  logic              cap_irq  = 1'b0;
  logic              rd_arm   = 1'b0;
  logic              rd_abort = 1'b0;
  logic [ADDR_W-1:0] rd_step  = '0;
  logic [ADDR_W-1:0] rdaddr;
  logic [DATA_W-1:0] rddata;
  logic              cap_en;
  logic              rd_busy;
  logic              rd_done;

  dso_rd_ctrl_if #(.DATA_W(DATA_W)) smp_if ();

  dso_rd_ctrl #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .REARM_CYC (REARM_CYC)
  ) dut (
    .clk_rd   (clk_rd),
    .rst_n    (rst_n),
    .cap_irq  (cap_irq),
    .rd_arm   (rd_arm),
    .rd_abort (rd_abort),
    .rd_step  (rd_step),
    .rdaddr   (rdaddr),
    .rddata   (rddata),
    .smp      (smp_if),
    .cap_en   (cap_en),
    .rd_busy  (rd_busy),
    .rd_done  (rd_done)
  );

  always #5 clk_rd = ~clk_rd;

  // RAM model with registered read.
  logic [7:0] mem [DEPTH];
  always @(posedge clk_rd) rddata <= mem[rdaddr];

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  int   acc_cnt, done_cnt, last_acc_addr, low_run, last_low_run;
  int   stall_pct = 0;
  logic prev_stall = 1'b0, prev_acc_last = 1'b0, prev_last = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Sink: random back-pressure.
  initial begin
    smp_if.smp_ready = 1'b1;
    forever begin
      @(posedge clk_rd);
      #1;
      smp_if.smp_ready = (stall_pct == 0) ? 1'b1 : (int'($urandom_range(0, 99)) >= stall_pct);
    end
  end

  // Monitor: scoreboard pop on accept, stall stability, rd_done timing, cap_en pulse width.
  always @(negedge clk_rd) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall    = 1'b0;
      prev_acc_last = 1'b0;
      low_run       = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", int'(smp_if.smp_valid), 1);
        chk("stall_data", int'(smp_if.smp_data), int'(prev_data));
        chk("stall_last", int'(smp_if.smp_last), int'(prev_last));
      end
      if (prev_acc_last) chk("done_after_last", int'(rd_done), 1);
      else if (rd_done) chk("spurious_done", int'(rd_done), 0);
      if (rd_done) done_cnt++;
      prev_acc_last = 1'b0;
      if (smp_if.smp_valid && smp_if.smp_ready && !rd_abort) begin
        acc_cnt++;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sample: got data %0d expected none", smp_if.smp_data);
        end else begin
          e = sb_q.pop_front();
          chk("smp_data", int'(smp_if.smp_data), int'(e.data));
          chk("smp_last", int'(smp_if.smp_last), int'(e.last));
          chk("smp_addr", int'(rdaddr), e.addr);
        end
        last_acc_addr = int'(rdaddr);
        prev_acc_last = smp_if.smp_last;
      end
      prev_stall = smp_if.smp_valid && !smp_if.smp_ready && !rd_abort;
      prev_data  = smp_if.smp_data;
      prev_last  = smp_if.smp_last;
      if (!cap_en) low_run++;
      else if (low_run > 0) begin
        last_low_run = low_run;
        low_run      = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_rd);
      #1;
    end
  endtask

  task automatic fill_mem(input int rnd);
    for (int a = 0; a < DEPTH; a++) mem[a] = (rnd != 0) ? 8'($urandom) : 8'(a);
  endtask

  task automatic push_exp(input int step);
    int   se;
    int   a;
    exp_t e;
    se = (step == 0) ? 1 : step;
    a  = 0;
    while (a < DEPTH) begin
      e.data = mem[a];
      e.last = (a + se >= DEPTH);
      e.addr = a;
      sb_q.push_back(e);
      a += se;
    end
  endtask

  task automatic clear_stats();
    acc_cnt       = 0;
    done_cnt      = 0;
    last_low_run  = 0;
    last_acc_addr = -1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (rd_busy && n < budget) begin
      tick(1);
      n++;
    end
    chk(name, int'(rd_busy), 0);
  endtask

  task automatic run_frame(input frame_t f);
    int lat;
    fill_mem(f.rnd);
    sb_q.delete();
    clear_stats();
    stall_pct = f.stall;
    rd_step   = ADDR_W'(f.step);
    push_exp(f.step);
    cap_irq = 1'b1;
    lat     = 0;
    while (!smp_if.smp_valid && lat < 20) begin
      tick(1);
      lat++;
      if (lat == 4) cap_irq = 1'b0;
    end
    cap_irq = 1'b0;
    chk("first_valid_latency", lat, 5);
    wait_idle("frame_end", 20000);
    chk("n_samples", acc_cnt, f.exp_n);
    chk("last_addr", last_acc_addr, f.exp_last);
    chk("done_pulses", done_cnt, 1);
    chk("cap_en_low", last_low_run, REARM_CYC);
    chk("sb_empty", sb_q.size(), 0);
    $display("frame step=%0d stall=%0d samples=%0d last_addr=%0d done=%0d", f.step, f.stall,
             acc_cnt, last_acc_addr, done_cnt);
    tick(3);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t tab[10];
    int     n;
    tab[0] = '{1,   0,  0, 512, 511};
    tab[1] = '{3,   0,  0, 171, 510};
    tab[2] = '{0,   0,  0, 512, 511};
    tab[3] = '{1,   50, 1, 512, 511};
    tab[4] = '{3,   50, 1, 171, 510};
    tab[5] = '{7,   0,  1, 74,  511};
    tab[6] = '{256, 0,  1, 2,   256};
    tab[7] = '{511, 30, 1, 2,   511};
    tab[8] = '{300, 0,  0, 2,   300};
    tab[9] = '{5,   50, 1, 103, 510};

    fill_mem(0);
    clear_stats();
    tick(3);
    chk("rst_rdaddr", int'(rdaddr), 0);
    chk("rst_valid", int'(smp_if.smp_valid), 0);
    chk("rst_last", int'(smp_if.smp_last), 0);
    chk("rst_data", int'(smp_if.smp_data), 0);
    chk("rst_cap_en", int'(cap_en), 1);
    chk("rst_busy", int'(rd_busy), 0);
    chk("rst_done", int'(rd_done), 0);
    rst_n  = 1'b1;
    rd_arm = 1'b1;
    tick(3);

    for (int i = 0; i < 10; i++) run_frame(tab[i]);

    // Abort while the 100th sample is presented.
    fill_mem(0);
    sb_q.delete();
    clear_stats();
    stall_pct = 0;
    rd_step   = ADDR_W'(1);
    push_exp(1);
    cap_irq = 1'b1;
    n       = 0;
    while (!(smp_if.smp_valid && acc_cnt == 99) && n < 2000) begin
      tick(1);
      n++;
      if (n == 4) cap_irq = 1'b0;
    end
    cap_irq = 1'b0;
    chk("abort_at_100", acc_cnt, 99);
    rd_abort = 1'b1;
    tick(1);
    rd_abort = 1'b0;
    chk("abort_valid_drop", int'(smp_if.smp_valid), 0);
    chk("abort_last_drop", int'(smp_if.smp_last), 0);
    wait_idle("abort_idle", 100);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_cap_en_low", last_low_run, REARM_CYC);
    chk("abort_count", acc_cnt, 99);
    $display("abort samples=%0d done=%0d cap_en_low=%0d", acc_cnt, done_cnt, last_low_run);
    sb_q.delete();
    tick(3);
    run_frame(tab[0]);

    // irq held high through REARM, then rd_arm gating and level-high no-start.
    fill_mem(0);
    sb_q.delete();
    clear_stats();
    stall_pct = 0;
    rd_step   = ADDR_W'(64);
    push_exp(64);
    cap_irq = 1'b1;
    n       = 0;
    while (done_cnt == 0 && n < 500) begin
      tick(1);
      n++;
    end
    chk("held_done", done_cnt, 1);
    tick(30);
    chk("held_busy", int'(rd_busy), 1);
    chk("held_cap_en", int'(cap_en), 1);
    chk("held_cap_en_low", last_low_run, REARM_CYC);
    chk("held_count", acc_cnt, 8);
    cap_irq = 1'b0;
    wait_idle("held_release", 20);
    clear_stats();
    rd_arm  = 1'b0;
    cap_irq = 1'b1;
    tick(30);
    chk("disarmed_busy", int'(rd_busy), 0);
    rd_arm = 1'b1;
    tick(30);
    chk("level_high_busy", int'(rd_busy), 0);
    chk("no_sample", acc_cnt, 0);
    $display("irq_hold samples=%0d busy=%0d", acc_cnt, rd_busy);
    cap_irq = 1'b0;
    tick(5);
    run_frame(tab[1]);

    // Reset asserted while a sample is stalled in HOLD.
    fill_mem(1);
    mem[0] = 8'hA5;
    sb_q.delete();
    clear_stats();
    stall_pct = 100;
    rd_step   = ADDR_W'(1);
    push_exp(1);
    cap_irq = 1'b1;
    n       = 0;
    while (!smp_if.smp_valid && n < 20) begin
      tick(1);
      n++;
      if (n == 4) cap_irq = 1'b0;
    end
    cap_irq = 1'b0;
    chk("hold_reached", int'(smp_if.smp_valid), 1);
    tick(3);
    rst_n = 1'b0;
    #1;
    chk("midrst_rdaddr", int'(rdaddr), 0);
    chk("midrst_valid", int'(smp_if.smp_valid), 0);
    chk("midrst_data", int'(smp_if.smp_data), 0);
    chk("midrst_last", int'(smp_if.smp_last), 0);
    chk("midrst_cap_en", int'(cap_en), 1);
    chk("midrst_busy", int'(rd_busy), 0);
    chk("midrst_done", int'(rd_done), 0);
    $display("midframe_reset valid=%0d busy=%0d", smp_if.smp_valid, rd_busy);
    sb_q.delete();
    stall_pct = 0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    run_frame(tab[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
